// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: sequential adder/subtractor that walks WIDTH-bit operands
// DIGIT bits per clock through a single full-adder slice with a registered
// carry/borrow, using a start/busy/done handshake.
// Optional build macro: ADDSUB_OVERFLOW_EN enables the signed-overflow flag;
// without it ovf is tied low and no MSB carry-in tracking is built.
module digit_serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NDIG = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   generate
      if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
         $error("digit_serial_addsub: WIDTH must be a non-zero multiple of DIGIT and DIGIT <= WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             mode_r;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [DIGIT-1:0] b_eff;
   logic [DIGIT:0]   digit_res;
   logic [WIDTH-1:0] sum_shift;
   logic             last;

   // One digit slice: low digit of A plus (possibly inverted) low digit of B plus
   // the running carry; the result digit enters sum from the MSB end.
   always_comb begin
      b_eff     = b_sh[DIGIT-1:0] ^ {DIGIT{mode_r}};
      digit_res = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry};
      sum_shift = sum >> DIGIT;
      sum_shift[WIDTH-1 -: DIGIT] = digit_res[DIGIT-1:0];
      last      = (cnt == CW'(NDIG - 1));
   end

   // Next-state decode; start is only looked at in IDLE so a busy unit ignores it.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // State, operand shifters, carry chain and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         mode_r <= 1'b0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  mode_r <= mode;
                  carry  <= mode;
                  cnt    <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               carry <= digit_res[DIGIT];
               sum   <= sum_shift;
               cnt   <= cnt + CW'(1);
               if (last) cout <= digit_res[DIGIT] ^ mode_r;
            end
            default: ;
         endcase
      end
   end

`ifdef ADDSUB_OVERFLOW_EN
   logic msb_cin;
   logic ovf_r;

   // Carry into the MSB is recovered from the MSB sum bit and its two inputs.
   always_comb begin
      msb_cin = digit_res[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_eff[DIGIT-1];
   end

   // Signed overflow is latched on the final digit and held alongside sum.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if ((state == IDLE) && start) begin
         ovf_r <= 1'b0;
      end else if ((state == RUN) && last) begin
         ovf_r <= msb_cin ^ digit_res[DIGIT];
      end
   end

   assign ovf = ovf_r;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub: randomized and directed checks of digit_serial_addsub
// against a plain-arithmetic reference model, on an 8/1 and a 16/4 instance.
module tb_digit_serial_addsub;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        start8 = 1'b0;
   logic        start16 = 1'b0;
   logic        mode   = 1'b0;
   logic [15:0] a      = '0;
   logic [15:0] b      = '0;

   logic        busy8, done8, cout8, ovf8;
   logic [7:0]  sum8;
   logic        busy16, done16, cout16, ovf16;
   logic [15:0] sum16;

   int n_checks = 0;
   int n_fail   = 0;

   digit_serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode),
      .a(a[7:0]), .b(b[7:0]),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode),
      .a(a), .b(b),
      .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Counts one comparison and reports it when the observed value differs.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: unsigned modular result, carry/borrow, and signed overflow
   // derived from interpreting the operands as two's-complement integers.
   task automatic refModel(input int w, input bit m, input logic [15:0] x, input logic [15:0] y,
                           output logic [15:0] s, output bit c, output bit v);
      longint modv = longint'(1) << w;
      longint ux   = longint'(x) & (modv - 1);
      longint uy   = longint'(y) & (modv - 1);
      longint full;
      longint sx, sy, sres;
      full = m ? (ux - uy) : (ux + uy);
      c    = m ? (ux < uy) : (full >= modv);
      s    = 16'(full & (modv - 1));
      sx   = (ux >= modv / 2) ? ux - modv : ux;
      sy   = (uy >= modv / 2) ? uy - modv : uy;
      sres = m ? (sx - sy) : (sx + sy);
`ifdef ADDSUB_OVERFLOW_EN
      v = (sres > modv / 2 - 1) || (sres < -(modv / 2));
`else
      v = 1'b0;
`endif
   endtask

   // Runs one operation on the chosen instance and checks latency and results.
   task automatic applyStimulus(input bit wide, input bit m, input logic [15:0] x,
                                input logic [15:0] y, input string tag);
      logic [15:0] es;
      bit          ec, ev;
      int          ndig = wide ? 4 : 8;
      int          cyc;
      refModel(wide ? 16 : 8, m, x, y, es, ec, ev);
      mode = m;
      a    = x;
      b    = y;
      if (wide) start16 = 1'b1; else start8 = 1'b1;
      @(posedge clk); #1;
      start8  = 1'b0;
      start16 = 1'b0;
      a    = 16'($urandom);
      b    = 16'($urandom);
      mode = 1'($urandom);
      cyc  = 1;
      while (!(wide ? done16 : done8) && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput({tag, " latency"}, 32'(cyc), 32'(ndig + 1));
      checkOutput({tag, " sum"},  wide ? 32'(sum16) : 32'(sum8), 32'(es));
      checkOutput({tag, " cout"}, wide ? 32'(cout16) : 32'(cout8), 32'(ec));
      checkOutput({tag, " ovf"},  wide ? 32'(ovf16) : 32'(ovf8), 32'(ev));
      checkOutput({tag, " busy"}, wide ? 32'(busy16) : 32'(busy8), 32'd0);
      @(posedge clk); #1;
      checkOutput({tag, " done pulse"}, wide ? 32'(done16) : 32'(done8), 32'd0);
      checkOutput({tag, " sum held"}, wide ? 32'(sum16) : 32'(sum8), 32'(es));
   endtask

   initial begin
      int          pulses;
      int          cyc;
      logic [15:0] rx, ry;
      bit          rm;

      // Reset.
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      checkOutput("reset busy8", 32'(busy8), 32'd0);
      checkOutput("reset done8", 32'(done8), 32'd0);
      checkOutput("reset sum8",  32'(sum8),  32'd0);
      checkOutput("reset cout8", 32'(cout8), 32'd0);
      checkOutput("reset ovf8",  32'(ovf8),  32'd0);
      checkOutput("reset sum16", 32'(sum16), 32'd0);
      checkOutput("reset busy16", 32'(busy16), 32'd0);

      // Directed cases.
      applyStimulus(1'b0, 1'b0, 16'h005A, 16'h003C, "add 5A+3C");
      applyStimulus(1'b0, 1'b0, 16'h00FF, 16'h0001, "add FF+01");
      applyStimulus(1'b0, 1'b1, 16'h0010, 16'h0020, "sub 10-20");
      applyStimulus(1'b0, 1'b1, 16'h0020, 16'h0010, "sub 20-10");
      applyStimulus(1'b0, 1'b0, 16'h007F, 16'h0001, "add 7F+01");
      applyStimulus(1'b0, 1'b1, 16'h0080, 16'h0001, "sub 80-01");
      applyStimulus(1'b0, 1'b0, 16'h0005, 16'h0003, "add 05+03");
      applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'h0001, "w16 add FFFF+0001");
      applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0001, "w16 sub 0000-0001");

      // Start issued mid-operation must be ignored.
      mode = 1'b0; a = 16'h005A; b = 16'h003C; start8 = 1'b1;
      @(posedge clk); #1 start8 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start8 = 1'b1; a = 16'h0001;
      @(posedge clk); #1 start8 = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8) begin
            pulses++;
            checkOutput("ignored start sum", 32'(sum8), 32'h96);
         end
         @(posedge clk); #1;
      end
      checkOutput("ignored start done count", 32'(pulses), 32'd1);

      // Reset during RUN aborts without a done pulse.
      mode = 1'b0; a = 16'h005A; b = 16'h003C; start8 = 1'b1;
      @(posedge clk); #1 start8 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      checkOutput("abort busy", 32'(busy8), 32'd0);
      checkOutput("abort sum",  32'(sum8),  32'd0);
      checkOutput("abort done", 32'(done8), 32'd0);
      checkOutput("abort cout", 32'(cout8), 32'd0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8) pulses++;
         @(posedge clk); #1;
      end
      checkOutput("abort no done", 32'(pulses), 32'd0);
      applyStimulus(1'b0, 1'b1, 16'h0033, 16'h0044, "after abort sub 33-44");

      // Start held high: accepted again right after DONE.
      mode = 1'b0; a = 16'h0012; b = 16'h0034; start8 = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!done8 && cyc < 40);
      checkOutput("held start first latency", 32'(cyc), 32'd9);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!done8 && cyc < 40);
      start8 = 1'b0;
      checkOutput("held start period", 32'(cyc), 32'd10);
      checkOutput("held start sum", 32'(sum8), 32'h46);
      repeat (2) @(posedge clk);
      #1 checkOutput("held start released idle", 32'(busy8), 32'd0);

      // Randomized operations on both instances.
      for (int i = 0; i < 25; i++) begin
         rx = 16'($urandom);
         ry = 16'($urandom);
         rm = 1'($urandom);
         applyStimulus(1'b0, rm, {8'h00, rx[7:0]}, {8'h00, ry[7:0]}, $sformatf("rand8 #%0d", i));
         applyStimulus(1'b1, rm, rx, ry, $sformatf("rand16 #%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
